// File: rtl/lsu_perf_event_counter_if.sv
// LSU perf-counter bus: event strobes and controls in, coherent snapshot out.
// The master modport is the counter block, the slave modport is the event source/monitor side.
interface lsu_perf_event_counter_if #(
  parameter int LD_PORTS = 2,
  parameter int ST_PORTS = 1,
  parameter int CNT_W    = 32
);

  typedef struct packed {
    logic [CNT_W-1:0] total_loads;
    logic [CNT_W-1:0] total_stores;
    logic [CNT_W-1:0] forwarded_loads;
    logic [CNT_W-1:0] violated_loads;
    logic [CNT_W-1:0] bloom_filter_hits;
    logic [CNT_W-1:0] store_set_predictions;
    logic [CNT_W-1:0] false_positives;
    logic [CNT_W-1:0] false_negatives;
  } perf_counters_t;

  logic                          count_en;
  logic [$clog2(LD_PORTS+1)-1:0] ld_issue;
  logic [$clog2(ST_PORTS+1)-1:0] st_issue;
  logic [$clog2(LD_PORTS+1)-1:0] ld_fwd;
  logic                          ld_violation;
  logic                          bloom_hit;
  logic                          ss_pred;
  logic                          ss_false_pos;
  logic                          ss_false_neg;
  logic                          clear_counters;
  logic                          snap_req;
  logic                          snap_valid;
  logic                          snap_ack;
  perf_counters_t                counters_out;
  logic [7:0]                    sat_flags;

  modport master (
    input  count_en, ld_issue, st_issue, ld_fwd, ld_violation, bloom_hit,
           ss_pred, ss_false_pos, ss_false_neg, clear_counters, snap_req, snap_ack,
    output snap_valid, counters_out, sat_flags
  );

  modport slave (
    output count_en, ld_issue, st_issue, ld_fwd, ld_violation, bloom_hit,
           ss_pred, ss_false_pos, ss_false_neg, clear_counters, snap_req, snap_ack,
    input  snap_valid, counters_out, sat_flags
  );

endinterface

// File: rtl/lsu_perf_event_counter.sv
// Saturating LSU/disambiguation event counters with a two-state snapshot handshake.
// Snapshot appears one cycle after snap_req and holds until snap_ack; counting never stalls.
module lsu_perf_event_counter #(
  parameter int LD_PORTS = 2,
  parameter int ST_PORTS = 1,
  parameter int CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  lsu_perf_event_counter_if.master bus
);

  localparam int LD_W    = $clog2(LD_PORTS + 1);
  localparam int ST_W    = $clog2(ST_PORTS + 1);
  localparam int NUM_CNT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } snap_state_t;

  logic [LD_W-1:0] ld_issue;
  logic [ST_W-1:0] st_issue;
  logic [LD_W-1:0] ld_fwd;

  logic [CNT_W-1:0]         evt      [NUM_CNT];
  logic [CNT_W-1:0]         live     [NUM_CNT];
  logic [CNT_W-1:0]         live_nxt [NUM_CNT];
  logic [NUM_CNT-1:0]       ovf;
  logic [NUM_CNT-1:0]       sat_q;
  logic [NUM_CNT*CNT_W-1:0] live_flat;
  logic [NUM_CNT*CNT_W-1:0] snap_q;
  logic                     snap_vld_q;
  snap_state_t              state;

  assign ld_issue = bus.ld_issue;
  assign st_issue = bus.st_issue;
  assign ld_fwd   = bus.ld_fwd;

  // Event slots follow the perf_counters_t field order.
  always_comb begin
    evt[0] = CNT_W'(ld_issue);
    evt[1] = CNT_W'(st_issue);
    evt[2] = CNT_W'(ld_fwd);
    evt[3] = CNT_W'(bus.ld_violation);
    evt[4] = CNT_W'(bus.bloom_hit);
    evt[5] = CNT_W'(bus.ss_pred);
    evt[6] = CNT_W'(bus.ss_false_pos);
    evt[7] = CNT_W'(bus.ss_false_neg);
  end

  always_comb begin
    ovf = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      live_nxt[i] = '0;
      {ovf[i], live_nxt[i]} = {1'b0, live[i]} + {1'b0, evt[i]};
      if (ovf[i]) begin
        live_nxt[i] = '1;
      end
    end
  end

  // Field 0 lands in the most significant slice, matching the struct layout.
  always_comb begin
    live_flat = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      live_flat[(NUM_CNT-1-i)*CNT_W +: CNT_W] = live[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        live[i] <= '0;
      end
      sat_q <= '0;
    end else if (bus.clear_counters) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        live[i] <= '0;
      end
      sat_q <= '0;
    end else if (bus.count_en) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        live[i] <= live_nxt[i];
        if (ovf[i]) begin
          sat_q[i] <= 1'b1;
        end
      end
    end
  end

  // Capture uses the register values of the request cycle, ahead of any update or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      snap_vld_q <= 1'b0;
      snap_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.snap_req) begin
            snap_q     <= live_flat;
            snap_vld_q <= 1'b1;
            state      <= VALID;
          end
        end
        VALID: begin
          if (bus.snap_ack) begin
            snap_vld_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          snap_vld_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.snap_valid   = snap_vld_q;
  assign bus.counters_out = snap_q;
  assign bus.sat_flags    = sat_q;

endmodule

// File: tb/tb_lsu_perf_event_counter.sv
// Drives a 32-bit and a 4-bit counter instance with identical stimulus and checks both against a queue-free array model.
module tb_lsu_perf_event_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       count_en, clear_counters, snap_req, snap_ack;
  logic       ld_violation, bloom_hit, ss_pred, ss_false_pos, ss_false_neg;
  logic [1:0] ld_issue, ld_fwd;
  logic [0:0] st_issue;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_perf_event_counter_if #(.LD_PORTS(2), .ST_PORTS(1), .CNT_W(32)) bus32 ();
  lsu_perf_event_counter_if #(.LD_PORTS(2), .ST_PORTS(1), .CNT_W(4))  bus4 ();

  assign bus32.count_en       = count_en;
  assign bus32.ld_issue       = ld_issue;
  assign bus32.st_issue       = st_issue;
  assign bus32.ld_fwd         = ld_fwd;
  assign bus32.ld_violation   = ld_violation;
  assign bus32.bloom_hit      = bloom_hit;
  assign bus32.ss_pred        = ss_pred;
  assign bus32.ss_false_pos   = ss_false_pos;
  assign bus32.ss_false_neg   = ss_false_neg;
  assign bus32.clear_counters = clear_counters;
  assign bus32.snap_req       = snap_req;
  assign bus32.snap_ack       = snap_ack;

  assign bus4.count_en       = count_en;
  assign bus4.ld_issue       = ld_issue;
  assign bus4.st_issue       = st_issue;
  assign bus4.ld_fwd         = ld_fwd;
  assign bus4.ld_violation   = ld_violation;
  assign bus4.bloom_hit      = bloom_hit;
  assign bus4.ss_pred        = ss_pred;
  assign bus4.ss_false_pos   = ss_false_pos;
  assign bus4.ss_false_neg   = ss_false_neg;
  assign bus4.clear_counters = clear_counters;
  assign bus4.snap_req       = snap_req;
  assign bus4.snap_ack       = snap_ack;

  lsu_perf_event_counter #(.LD_PORTS(2), .ST_PORTS(1), .CNT_W(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  lsu_perf_event_counter #(.LD_PORTS(2), .ST_PORTS(1), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  logic [255:0] cnt32;
  logic [31:0]  cnt4;
  assign cnt32 = bus32.counters_out;
  assign cnt4  = bus4.counters_out;

  // Reference model: index 0 is the 32-bit instance, index 1 the 4-bit one.
  longint m_live [2][8];
  longint m_snap [2][8];
  bit     m_sat  [2][8];
  bit     m_vld  [2];
  longint m_max  [2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint dut_field(input int d, input int i);
    if (d == 0) return longint'(cnt32[(7-i)*32 +: 32]);
    return longint'(cnt4[(7-i)*4 +: 4]);
  endfunction

  function automatic longint dut_vld(input int d);
    return (d == 0) ? longint'(bus32.snap_valid) : longint'(bus4.snap_valid);
  endfunction

  function automatic longint dut_sat(input int d);
    return (d == 0) ? longint'(bus32.sat_flags) : longint'(bus4.sat_flags);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_live[d][i] = 0;
        m_snap[d][i] = 0;
        m_sat[d][i]  = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    longint ev [8];
    ev[0] = ld_issue;     ev[1] = st_issue;  ev[2] = ld_fwd;        ev[3] = ld_violation;
    ev[4] = bloom_hit;    ev[5] = ss_pred;   ev[6] = ss_false_pos;  ev[7] = ss_false_neg;
    for (int d = 0; d < 2; d++) begin
      if (!m_vld[d] && snap_req) begin
        for (int i = 0; i < 8; i++) m_snap[d][i] = m_live[d][i];
        m_vld[d] = 1'b1;
      end else if (m_vld[d] && snap_ack) begin
        m_vld[d] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (clear_counters) begin
          m_live[d][i] = 0;
          m_sat[d][i]  = 1'b0;
        end else if (count_en) begin
          if (m_live[d][i] + ev[i] > m_max[d]) begin
            m_live[d][i] = m_max[d];
            m_sat[d][i]  = 1'b1;
          end else begin
            m_live[d][i] = m_live[d][i] + ev[i];
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_sat;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) exp_sat[i] = m_sat[d][i];
      chk($sformatf("d%0d_snap_valid", d), dut_vld(d), longint'(m_vld[d]));
      chk($sformatf("d%0d_sat_flags", d), dut_sat(d), longint'(exp_sat));
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("d%0d_field%0d", d, i), dut_field(d, i), m_snap[d][i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet();
    count_en = 1'b1; clear_counters = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
    ld_issue = '0; st_issue = '0; ld_fwd = '0; ld_violation = 1'b0;
    bloom_hit = 1'b0; ss_pred = 1'b0; ss_false_pos = 1'b0; ss_false_neg = 1'b0;
  endtask

  task automatic rand_events();
    ld_issue     = 2'($urandom_range(0, 2));
    ld_fwd       = 2'($urandom_range(0, 2));
    st_issue     = 1'($urandom_range(0, 1));
    ld_violation = 1'($urandom);
    bloom_hit    = 1'($urandom);
    ss_pred      = 1'($urandom);
    ss_false_pos = 1'($urandom);
    ss_false_neg = 1'($urandom);
  endtask

  task automatic do_snap();
    snap_req = 1'b1; step(); snap_req = 1'b0;
  endtask

  task automatic do_ack();
    snap_ack = 1'b1; step(); snap_ack = 1'b0;
  endtask

  task automatic do_clear();
    clear_counters = 1'b1; step(); clear_counters = 1'b0;
  endtask

  initial begin
    longint hold [8];
    longint frozen;
    quiet();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    check_all();

    // Idle then snapshot: all zero, valid one cycle after the request.
    repeat (10) step();
    do_snap();
    chk("idle_valid", dut_vld(0), 1);
    chk("idle_total_loads", dut_field(0, 0), 0);
    do_ack();
    chk("idle_ack_valid", dut_vld(0), 0);

    // Multi-port counting.
    do_clear();
    ld_issue = 2'd2; st_issue = 1'b1; ld_fwd = 2'd1;
    repeat (5) step();
    quiet();
    do_snap();
    chk("mp_total_loads", dut_field(0, 0), 10);
    chk("mp_total_stores", dut_field(0, 1), 5);
    chk("mp_fwd_loads", dut_field(0, 2), 5);
    do_ack();

    // Snapshot excludes the request cycle's events.
    do_clear();
    ld_issue = 2'd2;
    repeat (3) step();
    ld_issue = 2'd1;
    step();
    ld_issue = 2'd2;
    do_snap();
    ld_issue = 2'd0;
    chk("pre_update_snap", dut_field(0, 0), 7);
    do_ack();
    do_snap();
    chk("pre_update_next", dut_field(0, 0), 9);
    do_ack();

    // Clear with events and a request in the same cycle.
    do_clear();
    bloom_hit = 1'b1;
    repeat (3) step();
    clear_counters = 1'b1;
    do_snap();
    clear_counters = 1'b0;
    bloom_hit = 1'b0;
    chk("clear_prio_snap", dut_field(0, 4), 3);
    do_ack();
    do_snap();
    chk("clear_prio_after", dut_field(0, 4), 0);
    do_ack();

    // Saturation on the 4-bit instance.
    do_clear();
    ss_pred = 1'b1;
    repeat (17) step();
    ss_pred = 1'b0;
    do_snap();
    chk("sat4_value", dut_field(1, 5), 15);
    chk("sat4_flag", (dut_sat(1) >> 5) & 1, 1);
    chk("sat32_value", dut_field(0, 5), 17);
    do_ack();
    do_clear();
    chk("sat4_flag_cleared", dut_sat(1), 0);
    do_snap();
    chk("sat4_value_cleared", dut_field(1, 5), 0);
    do_ack();

    // Held snapshot while events keep flowing and ack is withheld.
    rand_events();
    do_snap();
    for (int i = 0; i < 8; i++) hold[i] = m_snap[0][i];
    for (int c = 0; c < 6; c++) begin
      rand_events();
      step();
    end
    quiet();
    chk("hold_valid", dut_vld(0), 1);
    for (int i = 0; i < 8; i++) chk($sformatf("hold_field%0d", i), dut_field(0, i), hold[i]);
    do_ack();
    chk("hold_release", dut_vld(0), 0);

    // Frozen counters: events with count_en=0 add nothing.
    frozen = m_live[0][0];
    count_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_events();
      ld_issue = 2'd2;
      step();
    end
    do_snap();
    do_ack();
    quiet();
    chk("frozen_total_loads", dut_field(0, 0), frozen);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      rand_events();
      count_en       = ($urandom_range(0, 7) != 0);
      clear_counters = ($urandom_range(0, 39) == 0);
      snap_req       = ($urandom_range(0, 2) == 0);
      snap_ack       = ($urandom_range(0, 2) == 0);
      step();
    end
    quiet();

    // Asynchronous reset mid-handshake drops the snapshot.
    ld_issue = 2'd2;
    repeat (3) step();
    do_snap();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", dut_vld(0), 0);
    chk("arst_field0", dut_field(0, 0), 0);
    @(negedge clk);
    rst = 1'b0;
    quiet();
    check_all();
    do_snap();
    chk("arst_live_zero", dut_field(0, 0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
